// File: rtl/execute_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*XLEN accumulator. Define MULDIV_FAST_MUL_EN for single-step multiplies.
`timescale 1ns/1ps

module execute_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
    localparam logic signed [XLEN-1:0] ZERO_S      = '0;
    localparam logic signed [XLEN-1:0] MINUS_ONE_S = '1;
    localparam logic signed [XLEN-1:0] MOST_NEG_S  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   m_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic              neg_r;
    logic              special_q;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    logic signed [XLEN-1:0] a_s, b_s;
    logic                   is_div, a_signed, b_signed, a_neg, b_neg;
    logic                   div_zero, div_ovf, special, skip_iter, accept;
    logic [XLEN-1:0]        mag_a, mag_b, preset;
    logic [2*XLEN-1:0]      mul_init;

    assign a_s      = op_a;
    assign b_s      = op_b;
    assign is_div   = funct3[2];
    assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg    = a_signed && (a_s < ZERO_S);
    assign b_neg    = b_signed && (b_s < ZERO_S);
    assign mag_a    = cond_neg(op_a, a_neg);
    assign mag_b    = cond_neg(op_b, b_neg);

    // Only signed DIV/REM (funct3[0]==0) can overflow.
    assign div_zero = is_div && (op_b == '0);
    assign div_ovf  = is_div && !funct3[0] && (a_s == MOST_NEG_S) && (b_s == MINUS_ONE_S);
    assign special  = div_zero || div_ovf;
    assign preset   = div_zero ? (funct3[1] ? op_a : '1)
                               : (funct3[1] ? '0 : op_a);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign mul_init  = fast_prod;
    assign skip_iter = special || !is_div;
`else
    assign mul_init  = {{XLEN{1'b0}}, mag_b};
    assign skip_iter = special;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE) && !flush;

    // Multiply step: conditionally add the multiplicand into the high half, shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m_q} : '0);
    assign mul_step = {mul_sum, acc[XLEN-1:1]};

    // Divide step: high half is the partial remainder, low half shifts dividend out / quotient in.
    logic [XLEN:0]     div_shift, div_diff, rem_ext;
    logic              div_ge;
    logic              div_unused;
    logic [2*XLEN-1:0] div_step;
    assign div_shift  = acc[2*XLEN-1:XLEN-1];
    assign div_ge     = (div_shift >= {1'b0, m_q});
    assign div_diff   = div_shift - {1'b0, m_q};
    assign rem_ext    = div_ge ? div_diff : div_shift;
    assign div_unused = rem_ext[XLEN];
    assign div_step   = {rem_ext[XLEN-1:0], acc[XLEN-2:0], div_ge};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
    assign prod_fix = cond_neg_w(acc, neg_q);
    assign quo_fix  = cond_neg(acc[XLEN-1:0], neg_q);
    assign rem_fix  = cond_neg(acc[2*XLEN-1:XLEN], neg_r);

    always_comb begin
        fix_res = '0;
        if (special_q) begin
            fix_res = acc[XLEN-1:0];
        end else if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q[1:0] == 2'b00) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) state_nxt = skip_iter ? FIX : ITER;
                ITER: if (cnt == LAST_ITER) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            if (accept) begin
                cnt <= '0;
            end else if (state == ITER) begin
                cnt <= cnt + CW'(1);
            end
            if ((state == FIX) && !flush) begin
                result <= fix_res;
                rd_out <= rd_q;
            end
        end
    end

    // Operand/accumulator path carries no reset; it is always reloaded on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= funct3;
            rd_q      <= rd_in;
            special_q <= special;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            m_q       <= is_div ? mag_b : mag_a;
            if (special) begin
                acc <= {{XLEN{1'b0}}, preset};
            end else if (is_div) begin
                acc <= {{XLEN{1'b0}}, mag_a};
            end else begin
                acc <= mul_init;
            end
        end else if (state == ITER) begin
            acc <= op_q[2] ? div_step : mul_step;
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Randomized and directed bench for execute_muldiv against an arithmetic reference model.
`timescale 1ns/1ps

module tb_execute_muldiv;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    string names[8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

    always #5 clk = ~clk;

    execute_muldiv #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct3   (funct3),
        .op_a     (op_a),
        .op_b     (op_b),
        .rd_in    (rd_in),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .rd_out   (rd_out),
        .busy     (busy)
    );

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0] u;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin u = {32'd0, a} * {32'd0, b}; return u[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 32'd0) return 2;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Presents one op from IDLE and waits (bounded) for out_valid; does not complete the handshake.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        in_valid = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_cnt = busy ? 1 : 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
        if (!out_valid) lat = -1;
        res = result;
        rdo = rd_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd_out got %0d want 0", rd_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [13] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3};
        logic [31:0] as  [13] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000,
                                  32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
        logic [31:0] bs  [13] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h10, 32'hFFFF_FFFF};
        logic [31:0] exs [13] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                                  32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF,
                                  32'h2345_6780, 32'hFFFF_FFFE};
        int          lats[13] = '{34, 34, 34, 34, 2, 2, 2, 2, 2, MUL_LAT, MUL_LAT, MUL_LAT, MUL_LAT};
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bcnt;
        for (int i = 0; i < 13; i++) begin
            do_op(f3s[i], as[i], bs[i], 5'(i + 1), res, rdo, lat, bcnt);
            checks++; if (res !== exs[i]) begin errors++; $display("FAIL dir_%s_%0d result got %h want %h", names[f3s[i]], i, res, exs[i]); end
            checks++; if (lat != lats[i]) begin errors++; $display("FAIL dir_%s_%0d latency got %0d want %0d", names[f3s[i]], i, lat, lats[i]); end
            checks++; if (rdo !== 5'(i + 1)) begin errors++; $display("FAIL dir_%s_%0d rd_out got %0d want %0d", names[f3s[i]], i, rdo, i + 1); end
            checks++; if (bcnt != lats[i]) begin errors++; $display("FAIL dir_%s_%0d busy_cycles got %0d want %0d", names[f3s[i]], i, bcnt, lats[i]); end
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL dir_%0d release in_ready=%0b out_valid=%0b want 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, exp, res;
        logic [4:0]  rd, rdo;
        int          lat, bcnt, elat;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = rnd_operand();
            b = rnd_operand();
            rd = 5'($urandom_range(0, 31));
            exp = model(f3, a, b);
            elat = exp_lat(f3, a, b);
            do_op(f3, a, b, rd, res, rdo, lat, bcnt);
            checks++; if (res !== exp) begin errors++; $display("FAIL rnd_%s a=%h b=%h result got %h want %h", names[f3], a, b, res, exp); end
            checks++; if (lat != elat) begin errors++; $display("FAIL rnd_%s a=%h b=%h latency got %0d want %0d", names[f3], a, b, lat, elat); end
            checks++; if (rdo !== rd) begin errors++; $display("FAIL rnd_%s rd_out got %0d want %0d", names[f3], rdo, rd); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, exp, res;
        logic [4:0]  rdo;
        int          lat, bcnt;
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        exp = model(3'd5, a, b);
        @(negedge clk);
        out_ready = 1'b0;
        do_op(3'd5, a, b, 5'd9, res, rdo, lat, bcnt);
        checks++; if (res !== exp || lat != XLEN + 2) begin
            errors++; $display("FAIL bp_first result got %h want %h latency got %0d want %0d", res, exp, lat, XLEN + 2);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (result !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold_%0d result=%h in_ready=%0b out_valid=%0b want %h/0/1", i, result, in_ready, out_valid, exp);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release in_ready=%0b busy=%0b want 1/0", in_ready, busy);
        end
    endtask

    task automatic test_flush();
        bit seen;
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd5; op_a = $urandom; op_b = 32'd3; rd_in = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_iter busy=%0b in_ready=%0b want 0/1", busy, in_ready);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_iter_no_valid got out_valid pulse %0b want 0", seen); end
    endtask

    task automatic test_flush_accept();
        bit seen;
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; funct3 = 3'd5; op_a = 32'd5; op_b = 32'd0; rd_in = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_accept busy got %0b want 0", busy); end
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (out_valid || busy) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_accept_idle activity got %0b want 0", seen); end
    endtask

    task automatic test_async_reset();
        logic [31:0] a, b, exp, res;
        logic [4:0]  rdo;
        int          lat, bcnt;
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd4; op_a = $urandom; op_b = 32'd7; rd_in = 5'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_ctrl out_valid=%0b busy=%0b in_ready=%0b want 0/0/1", out_valid, busy, in_ready);
        end
        checks++; if (result !== 32'd0 || rd_out !== 5'd0) begin
            errors++; $display("FAIL areset_data result=%h rd_out=%0d want 0/0", result, rd_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = $urandom;
        b = $urandom;
        exp = model(3'd1, a, b);
        do_op(3'd1, a, b, 5'd21, res, rdo, lat, bcnt);
        checks++; if (res !== exp || rdo !== 5'd21) begin
            errors++; $display("FAIL areset_after result got %h want %h rd got %0d want 21", res, exp, rdo);
        end
        checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL areset_after latency got %0d want %0d", lat, MUL_LAT); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a2, b2, exp2, r1;
        int          k, lat;
        a2 = $urandom;
        b2 = 32'($urandom_range(1, 50000));
        exp2 = model(3'd7, a2, b2);
        r1 = '0;
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd5; op_a = 32'd5; op_b = 32'd0; rd_in = 5'd1;
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            if (k == 0) begin funct3 = 3'd7; op_a = a2; op_b = b2; rd_in = 5'd2; end
            k++;
            if (k == 2) r1 = result;
        end while (!in_ready && k < 100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (k != 3) begin errors++; $display("FAIL b2b_spacing got %0d want 3", k); end
        checks++; if (r1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_first result got %h want ffffffff", r1); end
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (!out_valid || result !== exp2 || rd_out !== 5'd2) begin
            errors++; $display("FAIL b2b_second result got %h want %h rd got %0d want 2", result, exp2, rd_out);
        end
        checks++; if (lat != XLEN + 2) begin errors++; $display("FAIL b2b_second latency got %0d want %0d", lat, XLEN + 2); end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_flush_accept();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Iterative RV32M/RV64M multiply-divide unit that sits beside the execute-stage ALU. It accepts one M-extension operation through a valid/ready handshake and computes it over multiple cycles with a shift-add multiplier or a restoring divider. It holds the result until the memory stage takes it. The execute stage stalls decode while `busy` is high, and also drives `flush` on a taken jump or branch.

## Interface
- `XLEN`, default 32: operand and result width; legal values are 32 and 64.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: unit can accept; high only in IDLE.
- `funct3` input 3: M-extension opcode.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` input XLEN: rs1 value, already forwarded.
- `op_b` input XLEN: rs2 value, already forwarded.
- `rd_in` input 5: destination register tag.
- `flush` input 1: abort the in-flight operation and discard its result.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream takes the result.
- `result` output XLEN: final value.
- `rd_out` output 5: tag of the result.
- `busy` output 1: high in any state other than IDLE.

## Operation
- **States.** The FSM has four states: IDLE, ITER, FIX, DONE.
- **Acceptance.** An operation is accepted on a rising edge where `in_valid && in_ready`.
  - The unit latches `funct3` and `rd_in`.
  - It latches the operand magnitudes and the result-sign flag.
  - It clears the iteration counter, which is $clog2(XLEN)+1 bits wide.
- **Signedness per op.**
  - MULH: both operands signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV, REM: both signed.
  - MUL: its low XLEN bits are sign-agnostic and it is computed as unsigned.
- **Special-case detection at acceptance.** These cases skip ITER and go directly IDLE→FIX with a preset result.
  - Divide by zero (`op_b`==0): DIV/DIVU give all ones; REM/REMU give `op_a`.
  - Signed overflow (`op_a`==most-negative, `op_b`==all ones, DIV/REM only): DIV gives `op_a`; REM gives 0.
- **ITER.** The unit performs one step per cycle for exactly XLEN cycles, then moves to FIX.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring step; subtract the divisor from the shifted remainder and set the quotient bit if the result is non-negative.
- **FIX.** The unit applies two's-complement negation if the sign flag is set.
  - Multiply: negate the full 2·XLEN product.
  - Divide: the quotient sign is sign(a)^sign(b); the remainder sign is sign(a).
  - It then selects the output: the low half for MUL, the high half for MULH/MULHSU/MULHU, the quotient or the remainder.
  - It registers `result` and `rd_out`, then moves to DONE.
- **DONE.** `out_valid` is held high, with `result` and `rd_out` stable, until `out_ready`. On the edge where `out_valid && out_ready`, the unit goes to IDLE. No new operation is accepted in that same cycle.
- **flush.** `flush` takes priority over every other event.
  - On any edge with `flush`=1, the state goes to IDLE and `out_valid` goes to 0.
  - An `in_valid` in the same cycle is not accepted, even if the unit is in IDLE.
- **Reset.** `rst_n`=0 forces the following immediately, regardless of the clock:
  - State IDLE and counter 0.
  - `out_valid`=0, `result`=0, `rd_out`=0.
  - `busy`=0 and `in_ready`=1.
  - Reset in the middle of an operation discards that operation.

## Timing
- Let T be the acceptance edge.
- Normal ops:
  - Edge T enters ITER.
  - Edges T+1 through T+XLEN perform the iterations.
  - Edge T+XLEN enters FIX.
  - Edge T+XLEN+1 enters DONE.
  - `out_valid` is first high in the cycle after edge T+XLEN+1, which is 34 cycles for XLEN=32.
- Special cases: edge T enters FIX and edge T+1 enters DONE, giving a latency of 2.
- `in_ready` and `busy` are decoded from registered state and have no combinational path from the inputs.
- `out_valid` and `result` are registered.
- Throughput is one operation per latency+1 cycles when `out_ready` is held high.

## Configuration
- Macro `MULDIV_FAST_MUL_EN`.
- Defined:
  - The four multiply ops compute a full 2·XLEN signed/unsigned product combinationally at acceptance and go IDLE→FIX, so multiply latency is 2.
  - Divide behaviour is unchanged.
  - Synthesis infers a DSP multiplier.
- Undefined: multiply uses the iterative ITER path with latency XLEN+2, and no hardware multiplier is inferred.

## Test plan
- DIVU 100/7, `out_ready`=1 → `out_valid` high 34 cycles after acceptance with `result`=14. REMU on the same operands → 2.
- DIV -7/2 → `result`=0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF → 0x80000000 after 2 cycles. REM on the same operands → 0.
- DIVU 5/0 → 0xFFFFFFFF after 2 cycles. REMU 5/0 → 5. `busy` is high for exactly 2 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MUL 0x12345678×0x10 → 0x23456780. Latency is 34 without the macro and 2 with `MULDIV_FAST_MUL_EN`.
- Handshake and flush:
  - Hold `out_ready`=0 for 10 cycles in DONE → `result` stays stable and `in_ready`=0. Raise `out_ready` → the unit is back in IDLE the next cycle.
  - Assert `flush` at ITER cycle 5 → IDLE with no `out_valid` pulse.
  - Assert `flush` together with `in_valid` in IDLE → not accepted.
- Drive `rst_n` low asynchronously mid-ITER → outputs are 0 and `in_ready`=1 before the next clock edge. After release, an operation completes with the correct result.
